// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port synchronous memory between the instruction-fetch
// requester (i_*) and the MEM-stage data requester (d_*). One access is in
// flight at a time; the data port wins ties unless fetch has been passed over
// STARVE_MAX times in a row while it was requesting.
//
// Handshake: a requester raises *_req with stable address/controls and holds
// it until it samples *_ack high. *_ack is a one-cycle pulse and the matching
// *_rdata is valid in that cycle and held until the next read for that port.
// The owner's req is ignored during its ack cycle.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-low reset
//   i_req/i_addr          fetch request and word address
//   i_ack/i_rdata/i_stall fetch completion pulse, fetched word, stall
//   d_req/d_we/d_addr/d_wdata  data request, write enable, address, data
//   d_ack/d_rdata/d_stall data completion pulse, read word, stall
//   mem_en/mem_we/mem_addr/mem_wdata  registered memory strobe and controls
//   mem_rdata             memory read data, valid the cycle after mem_en
//   busy                  FSM not idle (registered)
//   dbg_state             current FSM state, for checkers
module mem_port_arbiter #(
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_ack,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_stall,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ack,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_stall,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic [1:0]        dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ACC  = 2'd1,
      S_CAP  = 2'd2,
      S_ACK  = 2'd3
   } state_t;

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   state_t              state_q, state_d;
   logic                own_d_q, own_d_d;     // 1: data port owns the access
   logic                lat_we_q, lat_we_d;
   logic [3:0]          starve_q, starve_d;
   logic                mem_en_q, mem_en_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic                i_ack_q, i_ack_d;
   logic                d_ack_q, d_ack_d;
   logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
   logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
   logic                busy_q, busy_d;
   logic                grant_i, grant_d;
   logic                i_pending;

   always_comb begin
      state_d     = state_q;
      own_d_d     = own_d_q;
      lat_we_d    = lat_we_q;
      starve_d    = starve_q;
      mem_en_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = '0;
      mem_wdata_d = '0;
      i_ack_d     = 1'b0;
      d_ack_d     = 1'b0;
      i_rdata_d   = i_rdata_q;
      d_rdata_d   = d_rdata_q;
      grant_i     = 1'b0;
      grant_d     = 1'b0;
      i_pending   = i_req;

      case (state_q)
         S_IDLE: begin
            // Data wins ties unless fetch has been starved long enough.
            if (d_req && !(i_req && starve_q == STARVE_LIM)) begin
               grant_d = 1'b1;
            end else if (i_req) begin
               grant_i = 1'b1;
            end
         end
         S_ACC: begin
            state_d = S_CAP;
         end
         S_CAP: begin
            state_d = S_ACK;
            if (own_d_q) begin
               d_ack_d = 1'b1;
               if (!lat_we_q) d_rdata_d = mem_rdata;
            end else begin
               i_ack_d = 1'b1;
               if (!lat_we_q) i_rdata_d = mem_rdata;
            end
         end
         default: begin
            // Only the non-owner may be handed the memory directly; the
            // owner's req is still the one it just had serviced.
            if (own_d_q && i_req) begin
               grant_i = 1'b1;
            end else if (!own_d_q && d_req) begin
               grant_d   = 1'b1;
               i_pending = 1'b0;
            end else begin
               state_d = S_IDLE;
            end
         end
      endcase

      if (grant_d) begin
         state_d     = S_ACC;
         own_d_d     = 1'b1;
         lat_we_d    = d_we;
         mem_en_d    = 1'b1;
         mem_we_d    = d_we;
         mem_addr_d  = d_addr;
         mem_wdata_d = d_wdata;
         if (i_pending && starve_q < STARVE_LIM) starve_d = starve_q + 4'd1;
      end else if (grant_i) begin
         state_d     = S_ACC;
         own_d_d     = 1'b0;
         lat_we_d    = 1'b0;
         mem_en_d    = 1'b1;
         mem_addr_d  = i_addr;
         starve_d    = 4'd0;
      end

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         own_d_q     <= 1'b0;
         lat_we_q    <= 1'b0;
         starve_q    <= 4'd0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         i_ack_q     <= 1'b0;
         d_ack_q     <= 1'b0;
         i_rdata_q   <= '0;
         d_rdata_q   <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         own_d_q     <= own_d_d;
         lat_we_q    <= lat_we_d;
         starve_q    <= starve_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         i_ack_q     <= i_ack_d;
         d_ack_q     <= d_ack_d;
         i_rdata_q   <= i_rdata_d;
         d_rdata_q   <= d_rdata_d;
         busy_q      <= busy_d;
      end
   end

   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign i_ack     = i_ack_q;
   assign d_ack     = d_ack_q;
   assign i_rdata   = i_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign busy      = busy_q;
   assign dbg_state = state_q;
   assign i_stall   = i_req & ~i_ack_q;
   assign d_stall   = d_req & ~d_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios plus a randomized run
// checked cycle by cycle against a behavioural model of the arbitration
// rules and a shadow copy of the memory.
module tb_mem_port_arbiter;
   localparam int AW = 8;
   localparam int DW = 32;
   localparam int SMAX = 3;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
   logic [AW-1:0] i_addr = '0, d_addr = '0;
   logic [DW-1:0] d_wdata = '0;
   logic i_ack, i_stall, d_ack, d_stall, mem_en, mem_we, busy;
   logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
   logic [DW-1:0] mem_rdata = '0;
   logic [AW-1:0] mem_addr;
   logic [1:0] dbg_state;

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_stall(i_stall),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata), .d_stall(d_stall),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   // Environment memory: synchronous single port, plus a preload port.
   logic [DW-1:0] mem_arr [0:255];
   logic          pl_en = 1'b0;
   logic [AW-1:0] pl_addr = '0;
   logic [DW-1:0] pl_data = '0;
   always @(posedge clk) begin
      if (pl_en) mem_arr[pl_addr] <= pl_data;
      if (mem_en) begin
         if (mem_we) mem_arr[mem_addr] <= mem_wdata;
         else        mem_rdata <= mem_arr[mem_addr];
      end
   end

   // Reference model: phase counter 0=idle,1=access,2=capture,3=ack.
   logic [DW-1:0] shadow [0:255];
   int            m_phase = 0;
   int            m_starve = 0;
   bit            m_data_owner = 1'b0;
   bit            m_we = 1'b0;
   logic [AW-1:0] m_addr = '0;
   logic [DW-1:0] m_wdata = '0;
   bit            e_en = 1'b0, e_we = 1'b0, e_iack = 1'b0, e_dack = 1'b0, e_busy = 1'b0;
   logic [AW-1:0] e_addr = '0;
   logic [DW-1:0] e_wdata = '0, e_irdata = '0, e_drdata = '0;

   int n_vec = 0;
   int n_err = 0;

   task automatic model_step();
      int  winner;     // 0 none, 1 fetch, 2 data
      bit  fetch_waiting;
      // A strobed write lands in memory at this edge even if reset is low.
      if (e_en && e_we) shadow[e_addr] = e_wdata;
      if (!reset) begin
         m_phase = 0; m_starve = 0;
         e_en = 0; e_we = 0; e_addr = '0; e_wdata = '0;
         e_iack = 0; e_dack = 0; e_irdata = '0; e_drdata = '0; e_busy = 0;
         return;
      end
      winner = 0;
      fetch_waiting = i_req && !(m_phase == 3 && !m_data_owner);
      e_iack = 0; e_dack = 0; e_en = 0;
      if (m_phase == 0) begin
         if (d_req && (!i_req || m_starve < SMAX)) winner = 2;
         else if (i_req) winner = 1;
      end else if (m_phase == 1) begin
         m_phase = 2;
      end else if (m_phase == 2) begin
         m_phase = 3;
         if (m_data_owner) e_dack = 1; else e_iack = 1;
         if (!m_we) begin
            if (m_data_owner) e_drdata = shadow[m_addr];
            else e_irdata = shadow[m_addr];
         end
      end else begin
         if (m_data_owner && i_req) winner = 1;
         else if (!m_data_owner && d_req) winner = 2;
         else m_phase = 0;
      end
      if (winner == 2) begin
         if (fetch_waiting) m_starve = (m_starve + 1 > SMAX) ? SMAX : m_starve + 1;
         m_data_owner = 1; m_we = d_we; m_addr = d_addr; m_wdata = d_wdata;
      end else if (winner == 1) begin
         m_starve = 0;
         m_data_owner = 0; m_we = 0; m_addr = i_addr; m_wdata = '0;
      end
      if (winner != 0) begin
         m_phase = 1;
         e_en = 1; e_we = m_we; e_addr = m_addr; e_wdata = m_wdata;
      end
      e_busy = (m_phase != 0);
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      i_req = 0; d_req = 0; d_we = 0;
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic preload();
      logic [DW-1:0] v;
      reset = 0;
      for (int a = 0; a < 256; a++) begin
         v = (a == 5) ? 32'hDEADBEEF : (a == 16) ? 32'h0000_00AA : $urandom;
         pl_en = 1; pl_addr = AW'(a); pl_data = v; shadow[a] = v;
         tick();
      end
      pl_en = 0;
   endtask

   task automatic test_reset();
      reset = 0;
      tick(); tick();
      n_vec++;
      if ({mem_en, mem_we, i_ack, d_ack, busy} !== 5'b0) begin
         n_err++; $display("FAIL reset_ctrl got=%b exp=00000", {mem_en, mem_we, i_ack, d_ack, busy});
      end
      n_vec++;
      if ({mem_addr, mem_wdata, i_rdata, d_rdata} !== '0) begin
         n_err++; $display("FAIL reset_data addr=%h wdata=%h irdata=%h drdata=%h exp=0", mem_addr, mem_wdata, i_rdata, d_rdata);
      end
      reset = 1;
      tick();
   endtask

   task automatic test_fetch_read();
      int lat;
      i_req = 1; i_addr = 8'd5;
      tick();
      n_vec++;
      if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 8'd5}) begin
         n_err++; $display("FAIL fetch_acc got en=%b we=%b addr=%h exp en=1 we=0 addr=05", mem_en, mem_we, mem_addr);
      end
      n_vec++;
      if (i_stall !== 1'b1) begin n_err++; $display("FAIL fetch_stall got=%b exp=1", i_stall); end
      lat = 1;
      while (!i_ack && lat < 10) begin tick(); lat++; end
      n_vec++;
      if (lat !== 3) begin n_err++; $display("FAIL fetch_latency got=%0d exp=3", lat); end
      n_vec++;
      if (i_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL fetch_rdata got=%h exp=deadbeef", i_rdata); end
      n_vec++;
      if (i_stall !== 1'b0) begin n_err++; $display("FAIL fetch_stall_ack got=%b exp=0", i_stall); end
      i_req = 0;
      tick();
      n_vec++;
      if (busy !== 1'b0) begin n_err++; $display("FAIL fetch_idle busy got=%b exp=0", busy); end
   endtask

   task automatic test_priority();
      int w;
      i_req = 1; i_addr = 8'd7; d_req = 1; d_we = 0; d_addr = 8'h10;
      tick();
      n_vec++;
      if ({mem_en, mem_addr} !== {1'b1, 8'h10}) begin
         n_err++; $display("FAIL prio_first got en=%b addr=%h exp en=1 addr=10", mem_en, mem_addr);
      end
      w = 0;
      while (!d_ack && w < 10) begin tick(); w++; end
      n_vec++;
      if (d_rdata !== 32'h0000_00AA || d_ack !== 1'b1) begin
         n_err++; $display("FAIL prio_data got ack=%b rdata=%h exp ack=1 rdata=000000aa", d_ack, d_rdata);
      end
      d_req = 0;
      tick();
      n_vec++;
      if ({mem_en, mem_addr} !== {1'b1, 8'd7}) begin
         n_err++; $display("FAIL prio_fetch_acc got en=%b addr=%h exp en=1 addr=07", mem_en, mem_addr);
      end
      tick(); tick();
      n_vec++;
      if (i_ack !== 1'b1 || i_rdata !== shadow[7]) begin
         n_err++; $display("FAIL prio_fetch_ack got ack=%b rdata=%h exp ack=1 rdata=%h", i_ack, i_rdata, shadow[7]);
      end
      idle(2);
   endtask

   task automatic test_write();
      int w;
      d_req = 1; d_we = 1; d_addr = 8'h20; d_wdata = 32'h12345678;
      tick();
      n_vec++;
      if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 8'h20, 32'h12345678}) begin
         n_err++; $display("FAIL write_acc got en=%b we=%b addr=%h wdata=%h", mem_en, mem_we, mem_addr, mem_wdata);
      end
      tick();
      n_vec++;
      if (mem_en !== 1'b0) begin n_err++; $display("FAIL write_single got en=%b exp=0", mem_en); end
      tick();
      n_vec++;
      if (d_ack !== 1'b1) begin n_err++; $display("FAIL write_ack got=%b exp=1", d_ack); end
      d_we = 0;
      w = 0;
      tick();
      while (!d_ack && w < 10) begin tick(); w++; end
      n_vec++;
      if (d_ack !== 1'b1 || d_rdata !== 32'h12345678) begin
         n_err++; $display("FAIL write_readback got ack=%b rdata=%h exp=12345678", d_ack, d_rdata);
      end
      idle(2);
   endtask

   task automatic test_starvation();
      int gaps[$];
      int run, fetches, w;
      run = 0; fetches = 0; w = 0;
      i_addr = 8'h31; d_addr = 8'h30; d_we = 0;
      while (fetches < 2 && w < 100) begin
         i_req = (m_phase == 0);
         d_req = 1;
         tick(); w++;
         if (mem_en) begin
            if (mem_addr == 8'h30) run++;
            else begin gaps.push_back(run); run = 0; fetches++; end
         end
      end
      n_vec++;
      if (fetches !== 2) begin n_err++; $display("FAIL starve_timeout fetch_grants=%0d exp=2", fetches); end
      else begin
         n_vec++;
         if (gaps[0] !== SMAX) begin n_err++; $display("FAIL starve_first got=%0d exp=%0d", gaps[0], SMAX); end
         n_vec++;
         if (gaps[1] !== SMAX + 1) begin n_err++; $display("FAIL starve_cleared got=%0d exp=%0d", gaps[1], SMAX + 1); end
      end
      idle(5);
   endtask

   task automatic test_reset_mid();
      int w;
      d_req = 1; d_we = 0; d_addr = 8'h10;
      tick(); tick();
      reset = 0;
      tick();
      n_vec++;
      if ({d_ack, busy, mem_en} !== 3'b0 || d_rdata !== '0) begin
         n_err++; $display("FAIL midreset got ack=%b busy=%b en=%b rdata=%h exp all 0", d_ack, busy, mem_en, d_rdata);
      end
      reset = 1;
      w = 0;
      tick();
      while (!d_ack && w < 10) begin tick(); w++; end
      n_vec++;
      if (d_ack !== 1'b1 || d_rdata !== 32'h0000_00AA) begin
         n_err++; $display("FAIL midreset_retry got ack=%b rdata=%h exp=000000aa", d_ack, d_rdata);
      end
      idle(2);
   endtask

   task automatic test_back_to_back();
      int w, gap;
      d_req = 1; d_we = 0; d_addr = 8'h20;
      w = 0;
      tick();
      while (!d_ack && w < 10) begin tick(); w++; end
      d_req = 0;
      tick();
      n_vec++;
      if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_idle busy got=%b exp=0", busy); end
      d_req = 1; d_addr = 8'd5;
      gap = 1;
      tick(); gap++;
      while (!d_ack && gap < 12) begin tick(); gap++; end
      n_vec++;
      if (gap !== 4) begin n_err++; $display("FAIL b2b_gap got=%0d exp=4", gap); end
      n_vec++;
      if (d_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL b2b_rdata got=%h exp=deadbeef", d_rdata); end
      idle(2);
   endtask

   task automatic test_random();
      for (int c = 0; c < 1500; c++) begin
         reset = (c % 211 == 100) ? 1'b0 : 1'b1;
         if (!i_req) begin
            if ($urandom_range(0, 3) == 0) begin i_req = 1; i_addr = AW'($urandom_range(0, 15)); end
         end else if (i_ack) begin
            i_req = $urandom_range(0, 1); i_addr = AW'($urandom_range(0, 15));
         end else if ($urandom_range(0, 30) == 0) i_req = 0;
         if (!d_req) begin
            if ($urandom_range(0, 2) == 0) begin
               d_req = 1; d_we = $urandom_range(0, 1);
               d_addr = AW'($urandom_range(0, 15)); d_wdata = $urandom;
            end
         end else if (d_ack) begin
            d_req = $urandom_range(0, 1); d_we = $urandom_range(0, 1);
            d_addr = AW'($urandom_range(0, 15)); d_wdata = $urandom;
         end else if ($urandom_range(0, 30) == 0) d_req = 0;
         tick();
         n_vec++;
         if ({mem_en, i_ack, d_ack, busy, i_stall, d_stall} !==
             {e_en, e_iack, e_dack, e_busy, i_req & ~e_iack, d_req & ~e_dack}) begin
            n_err++;
            $display("FAIL rand_ctrl cyc=%0d got en/iack/dack/busy/istall/dstall=%b exp=%b", c,
                     {mem_en, i_ack, d_ack, busy, i_stall, d_stall},
                     {e_en, e_iack, e_dack, e_busy, i_req & ~e_iack, d_req & ~e_dack});
         end
         n_vec++;
         if (i_rdata !== e_irdata || d_rdata !== e_drdata) begin
            n_err++; $display("FAIL rand_rdata cyc=%0d got i=%h d=%h exp i=%h d=%h", c, i_rdata, d_rdata, e_irdata, e_drdata);
         end
         if (e_en) begin
            n_vec++;
            if (mem_we !== e_we || mem_addr !== e_addr || (e_we && mem_wdata !== e_wdata)) begin
               n_err++; $display("FAIL rand_mem cyc=%0d got we=%b addr=%h wdata=%h exp we=%b addr=%h wdata=%h",
                                 c, mem_we, mem_addr, mem_wdata, e_we, e_addr, e_wdata);
            end
         end
      end
      reset = 1;
      idle(6);
   endtask

   initial begin
      preload();
      test_reset();
      test_fetch_read();
      test_priority();
      test_write();
      test_starvation();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end
endmodule
